// File: rtl/fip_32_sqrt_seq.sv
// Sequential Q16.16 square root: restoring digit-by-digit root of x<<FRAC_BITS, one bit per clock.
// Define FIP_SQRT_ROUND_EN to round the result to nearest instead of truncating.
module fip_32_sqrt_seq #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned FRAC_BITS = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_x,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_neg
);

   localparam int unsigned RadW  = WIDTH + FRAC_BITS;
   localparam int unsigned NIter = RadW / 2;
   localparam int unsigned RootW = NIter;
   localparam int unsigned RemW  = FRAC_BITS / 2 + WIDTH / 2 + 2;
   localparam int unsigned CntW  = $clog2(NIter);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q, state_d;
   logic [RadW-1:0]   rad_q, rad_d;
   logic [RemW-1:0]   rem_q, rem_d;
   logic [RootW-1:0]  root_q, root_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              neg_q, neg_d;

   logic [RemW-1:0]   rem_sh, trial, rem_step;
   logic [RootW-1:0]  root_step;
   logic              ge;
   logic [WIDTH-1:0]  final_res;

   // One restoring iteration: bring down two radicand bits, try subtracting 4*root+1.
   always_comb begin
      rem_sh    = (rem_q << 2) | RemW'(rad_q[RadW-1 -: 2]);
      trial     = RemW'({root_q, 2'b01});
      ge        = (rem_sh >= trial);
      rem_step  = ge ? (rem_sh - trial) : rem_sh;
      root_step = {root_q[RootW-2:0], ge};
   end

`ifdef FIP_SQRT_ROUND_EN
   // rem > root is equivalent to N - r^2 > r, i.e. the exact root is at least r + 0.5.
   logic round_up;
   always_comb begin
      round_up  = (rem_step > RemW'(root_step));
      final_res = WIDTH'(root_step) + WIDTH'(round_up);
   end
`else
   always_comb begin
      final_res = WIDTH'(root_step);
   end
`endif

   always_comb begin
      state_d  = state_q;
      rad_d    = rad_q;
      rem_d    = rem_q;
      root_d   = root_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      neg_d    = neg_q;
      case (state_q)
         StIdle: begin
            if (i_valid) begin
               if (i_x[WIDTH-1]) begin
                  result_d = '0;
                  neg_d    = 1'b1;
                  state_d  = StDone;
               end else begin
                  rad_d   = {i_x, {FRAC_BITS{1'b0}}};
                  rem_d   = '0;
                  root_d  = '0;
                  cnt_d   = CntW'(NIter - 1);
                  neg_d   = 1'b0;
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            rad_d  = rad_q << 2;
            rem_d  = rem_step;
            root_d = root_step;
            cnt_d  = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
               result_d = final_res;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (i_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         rad_q    <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rad_q    <= rad_d;
         rem_q    <= rem_d;
         root_q   <= root_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         neg_q    <= neg_d;
      end
   end

   assign o_ready  = (state_q == StIdle);
   assign o_valid  = (state_q == StDone);
   assign o_result = result_q;
   assign o_neg    = neg_q;

endmodule
